// File: rtl/hazard_unit.sv
// ID-stage hazard detector for the 5-stage MIPS pipeline.
// Stalls on load-use and JR operand hazards, squashes wrong-path fetches
// on jumps and taken branches, and counts stall cycles (saturating).
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Inst,
  input  logic             BrTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [5:0] OP_RT   = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_SLTI = 6'd2;
  localparam logic [5:0] OP_LW   = 6'd3;
  localparam logic [5:0] OP_SW   = 6'd4;
  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_J    = 6'd6;
  localparam logic [5:0] OP_JR   = 6'd7;
  localparam logic [5:0] OP_JAL  = 6'd8;

  logic [5:0] opc;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opc = Inst[31:26];
  assign rs  = Inst[25:21];
  assign rt  = Inst[20:16];
  assign rd  = Inst[15:11];

  // Immediate/shamt/funct bits play no part in hazard detection.
  logic unused_bits;
  assign unused_bits = ^Inst[10:0];

  logic       uses_rs;
  logic       uses_rt;
  logic       id_wr_raw;
  logic       id_lw_raw;
  logic [4:0] id_dest;
  logic       id_wr;
  logic       id_lw;
  logic       is_jump;

  // Decode register usage and destination of the instruction sitting in ID.
  always_comb begin
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    id_wr_raw = 1'b0;
    id_lw_raw = 1'b0;
    id_dest   = 5'd0;
    is_jump   = 1'b0;
    case (opc)
      OP_RT: begin
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        id_wr_raw = 1'b1;
        id_dest   = rd;
      end
      OP_ADDI, OP_SLTI: begin
        uses_rs   = 1'b1;
        id_wr_raw = 1'b1;
        id_dest   = rt;
      end
      OP_LW: begin
        uses_rs   = 1'b1;
        id_wr_raw = 1'b1;
        id_lw_raw = 1'b1;
        id_dest   = rt;
      end
      OP_SW, OP_BEQ: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J: begin
        is_jump = 1'b1;
      end
      OP_JR: begin
        uses_rs = 1'b1;
        is_jump = 1'b1;
      end
      OP_JAL: begin
        id_wr_raw = 1'b1;
        id_dest   = 5'd31;
        is_jump   = 1'b1;
      end
      default: begin
        uses_rs = 1'b0;
      end
    endcase
  end

  // Writes to $0 are discarded by the register file, so they never create a hazard.
  assign id_wr = id_wr_raw & (id_dest != 5'd0);
  assign id_lw = id_lw_raw & id_wr;

  logic       ex_wr;
  logic [4:0] ex_rd;
  logic       ex_lw;
  logic       mem_wr;
  logic [4:0] mem_rd;

  logic load_use;
  logic jr_haz;
  logic stall;

  // Hazard terms against the writers currently in EX and MEM.
  always_comb begin
    load_use = ex_lw & ex_wr &
               ((uses_rs & (rs == ex_rd)) | (uses_rt & (rt == ex_rd)));
    jr_haz   = (opc == OP_JR) &
               ((ex_wr & (rs == ex_rd)) | (mem_wr & (rs == mem_rd)));
    stall    = load_use | jr_haz;
  end

  // Pipeline control, with reset over taken branch over stall over jump.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    if (!rst) begin
      PCWrite = 1'b1;
    end else if (BrTaken) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (stall) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (is_jump) begin
      IFIDFlush = 1'b1;
    end
  end

  // Shadow the EX and MEM writers; a bubble into ID/EX leaves no writer behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_wr  <= 1'b0;
      ex_rd  <= 5'd0;
      ex_lw  <= 1'b0;
      mem_wr <= 1'b0;
      mem_rd <= 5'd0;
    end else begin
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (IDEXBubble) begin
        ex_wr <= 1'b0;
        ex_rd <= 5'd0;
        ex_lw <= 1'b0;
      end else begin
        ex_wr <= id_wr;
        ex_rd <= id_dest;
        ex_lw <= id_lw;
      end
    end
  end

  // Count cycles in which the PC was held, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      StallCount <= '0;
    end else if (!PCWrite && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed pipeline scenarios followed by
// random instruction streams, all checked against an instruction-level model.
module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic [31:0] Inst;
  logic        BrTaken;

  logic        pcw,  ifw,  flush,  bub;
  logic [15:0] cnt;
  logic        pcw2, ifw2, flush2, bub2;
  logic [1:0]  cnt2;

  hazard_unit dut (
    .clk(clk), .rst(rst), .Inst(Inst), .BrTaken(BrTaken),
    .PCWrite(pcw), .IFIDWrite(ifw), .IFIDFlush(flush), .IDEXBubble(bub),
    .StallCount(cnt)
  );

  hazard_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .Inst(Inst), .BrTaken(BrTaken),
    .PCWrite(pcw2), .IFIDWrite(ifw2), .IFIDFlush(flush2), .IDEXBubble(bub2),
    .StallCount(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction-level model: what occupies EX and MEM (BUB = nothing).
  localparam logic [31:0] BUB = 32'hFC00_0000;
  logic [31:0] mEx, mMem;
  int          mCnt16, mCnt2;

  logic ePcw, eIfw, eFlush, eBub, eStall;
  logic obsStall, obsFlush, obsBub, obsPcw;

  function automatic logic [31:0] rtype(input int s, input int t, input int d);
    rtype = {6'd0, 5'(s), 5'(t), 5'(d), 11'd0};
  endfunction

  function automatic logic [31:0] itype(input int op, input int s, input int t, input int imm);
    itype = {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic int opOf(input logic [31:0] i);
    opOf = int'(i[31:26]);
  endfunction

  // Register an instruction will write, or 0 when it writes nothing that matters.
  function automatic int destOf(input logic [31:0] i);
    case (opOf(i))
      0:       destOf = int'(i[15:11]);
      1, 2, 3: destOf = int'(i[20:16]);
      8:       destOf = 31;
      default: destOf = 0;
    endcase
  endfunction

  function automatic bit readsReg(input logic [31:0] i, input int r);
    case (opOf(i))
      0, 4, 5:    readsReg = (int'(i[25:21]) == r) || (int'(i[20:16]) == r);
      1, 2, 3, 7: readsReg = (int'(i[25:21]) == r);
      default:    readsReg = 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage cycle, check every output, then advance the model.
  task automatic applyStimulus(input logic [31:0] inst, input logic br, input logic rv, input string tag);
    int  dEx, dMem, op;
    bit  lu, jh;
    Inst = inst; BrTaken = br; rst = rv;
    dEx  = destOf(mEx);
    dMem = destOf(mMem);
    op   = opOf(inst);
    lu   = (opOf(mEx) == 3) && (dEx != 0) && readsReg(inst, dEx);
    jh   = (op == 7) && (((dEx != 0) && (int'(inst[25:21]) == dEx)) ||
                         ((dMem != 0) && (int'(inst[25:21]) == dMem)));
    eStall = lu || jh;
    if (!rv)          {ePcw, eIfw, eFlush, eBub} = 4'b1100;
    else if (br)      {ePcw, eIfw, eFlush, eBub} = 4'b1111;
    else if (eStall)  {ePcw, eIfw, eFlush, eBub} = 4'b0001;
    else if (op == 6 || op == 7 || op == 8) {ePcw, eIfw, eFlush, eBub} = 4'b1110;
    else              {ePcw, eIfw, eFlush, eBub} = 4'b1100;
    @(negedge clk);
    checkOutput({tag, ".PCWrite"},    32'(pcw),   32'(ePcw));
    checkOutput({tag, ".IFIDWrite"},  32'(ifw),   32'(eIfw));
    checkOutput({tag, ".IFIDFlush"},  32'(flush), 32'(eFlush));
    checkOutput({tag, ".IDEXBubble"}, 32'(bub),   32'(eBub));
    checkOutput({tag, ".StallCount"}, 32'(cnt),   32'(mCnt16));
    checkOutput({tag, ".PCWrite2"},   32'(pcw2),  32'(ePcw));
    checkOutput({tag, ".Flush2"},     32'(flush2), 32'(eFlush));
    checkOutput({tag, ".StallCount2"}, 32'(cnt2), 32'(mCnt2));
    obsStall = ~pcw;
    obsPcw   = pcw;
    obsFlush = flush;
    obsBub   = bub;
    @(posedge clk);
    #1;
    if (!rv) begin
      mEx = BUB; mMem = BUB; mCnt16 = 0; mCnt2 = 0;
    end else begin
      mMem = mEx;
      mEx  = eBub ? BUB : inst;
      if (!ePcw) begin
        if (mCnt16 < 65535) mCnt16++;
        if (mCnt2 < 3)      mCnt2++;
      end
    end
  endtask

  // Hold an instruction in ID until the model lets it leave; count DUT stalls.
  task automatic runInst(input logic [31:0] inst, input string tag, output int stalls);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(inst, 1'b0, 1'b1, tag);
      if (obsStall) stalls++;
      if (!eStall) break;
    end
  endtask

  task automatic doReset();
    applyStimulus(32'd0, 1'b0, 1'b0, "reset");
  endtask

  logic [31:0] ADD324, LW21, NOP, JR5, ADDI5;
  int s;

  initial begin
    rst = 1'b0; Inst = 32'd0; BrTaken = 1'b0;
    mEx = BUB; mMem = BUB; mCnt16 = 0; mCnt2 = 0;
    @(posedge clk);
    #1;
    ADD324 = rtype(2, 4, 3);
    LW21   = itype(3, 1, 2, 0);
    NOP    = 32'd0;
    JR5    = itype(7, 5, 0, 0);
    ADDI5  = itype(1, 0, 5, 4);

    // Reset state
    doReset();
    checkOutput("rst.count", 32'(cnt), 32'd0);

    // 1: load-use, one stall
    runInst(LW21, "t1.lw", s);
    runInst(ADD324, "t1.add", s);
    checkOutput("t1.stalls", 32'(s), 32'd1);
    runInst(NOP, "t1.nop", s);
    checkOutput("t1.count", 32'(cnt), 32'd1);

    // 2: $0 destination and SW never stall
    runInst(itype(3, 1, 0, 0), "t2.lw0", s);
    runInst(rtype(0, 0, 3), "t2.add0", s);
    checkOutput("t2.stalls0", 32'(s), 32'd0);
    runInst(itype(4, 1, 2, 0), "t2.sw", s);
    runInst(rtype(2, 2, 3), "t2.add", s);
    checkOutput("t2.stallsSw", 32'(s), 32'd0);

    // 3: writer then JR at distance 1, 2, 3
    runInst(ADDI5, "t3a.addi", s);
    runInst(JR5, "t3a.jr", s);
    checkOutput("t3a.stalls", 32'(s), 32'd2);
    checkOutput("t3a.flush", 32'(obsFlush), 32'd1);
    runInst(NOP, "t3a.wp", s);
    runInst(ADDI5, "t3b.addi", s);
    runInst(NOP, "t3b.nop", s);
    runInst(JR5, "t3b.jr", s);
    checkOutput("t3b.stalls", 32'(s), 32'd1);
    runInst(NOP, "t3b.wp", s);
    runInst(ADDI5, "t3c.addi", s);
    runInst(NOP, "t3c.nop1", s);
    runInst(NOP, "t3c.nop2", s);
    runInst(JR5, "t3c.jr", s);
    checkOutput("t3c.stalls", 32'(s), 32'd0);
    checkOutput("t3c.flush", 32'(obsFlush), 32'd1);
    runInst(NOP, "t3c.wp", s);
    // LW then JR on loaded register
    runInst(itype(3, 1, 5, 0), "t3d.lw", s);
    runInst(JR5, "t3d.jr", s);
    checkOutput("t3d.stalls", 32'(s), 32'd2);

    // 4: taken branch overrides a load-use stall
    runInst(LW21, "t4.lw", s);
    applyStimulus(ADD324, 1'b1, 1'b1, "t4.br");
    checkOutput("t4.pcw", 32'(obsPcw), 32'd1);
    checkOutput("t4.flush", 32'(obsFlush), 32'd1);
    checkOutput("t4.bub", 32'(obsBub), 32'd1);
    applyStimulus(ADD324, 1'b0, 1'b1, "t4.after");
    checkOutput("t4.nostall", 32'(obsStall), 32'd0);

    // 5: J and JAL flush without bubble; JAL link forwarded
    runInst({6'd6, 26'h123}, "t5.j", s);
    checkOutput("t5.jflush", 32'(obsFlush), 32'd1);
    checkOutput("t5.jbub", 32'(obsBub), 32'd0);
    runInst({6'd8, 26'h40}, "t5.jal", s);
    runInst(rtype(31, 0, 3), "t5.add31", s);
    checkOutput("t5.stalls", 32'(s), 32'd0);

    // 6: saturation of the narrow counter, then reset during a stall
    doReset();
    for (int n = 0; n < 5; n++) begin
      runInst(LW21, "t6.lw", s);
      runInst(ADD324, "t6.add", s);
    end
    checkOutput("t6.cnt2", 32'(cnt2), 32'd3);
    checkOutput("t6.cnt16", 32'(cnt), 32'd5);
    runInst(LW21, "t6.lw", s);
    applyStimulus(ADD324, 1'b0, 1'b0, "t6.rstmid");
    checkOutput("t6.rstpcw", 32'(obsPcw), 32'd1);
    applyStimulus(ADD324, 1'b0, 1'b1, "t6.post");
    checkOutput("t6.nostall", 32'(obsStall), 32'd0);
    checkOutput("t6.cntclr", 32'(cnt2), 32'd0);

    // Random instruction streams over a small register set
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ri;
      int          op;
      logic        rb, rr;
      op = int'($urandom_range(0, 10));
      if (op == 10) op = int'($urandom_range(9, 63));
      ri = {6'(op), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
      if (op == 8 && ($urandom_range(0, 1) == 1)) ri = rtype(31, 1, 2);
      rb = ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 59) != 0);
      applyStimulus(ri, rb, rr, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
